// File: rtl/gs_digit_entry_pkg.sv
// Shared definitions for the Options-menu digit entry path: state encoding,
// per-field legal ranges and the digit lengths shared with the decimalizer.
package gs_digit_entry_pkg;

  typedef enum logic [1:0] {
    GSE_IDLE    = 2'd0,
    GSE_ENTRY   = 2'd1,
    GSE_CONVERT = 2'd2,
    GSE_DONE    = 2'd3
  } gs_entry_state_e;

  // Digit lengths must track the decimalizer so the edit field and readback agree.
  localparam int GS_DECIM_options_PIX_W_LEN   = 2;
  localparam int GS_DECIM_options_PIX_H_LEN   = 2;
  localparam int GS_DECIM_options_PALETTE_LEN = 1;

  localparam int GS_PIX_W_MIN = 1;
  localparam int GS_PIX_W_MAX = 63;
  localparam int GS_PIX_H_MIN = 1;
  localparam int GS_PIX_H_MAX = 63;

  localparam int GS_PALETTES_COUNT = 8;
  localparam int GS_PALETTE_MIN    = 0;
  localparam int GS_PALETTE_MAX    = GS_PALETTES_COUNT - 1;

  // Accumulator width able to hold any n-digit decimal number (10^n < 16^n).
  function automatic int gs_bcd_acc_width(input int n_digits);
    return 4 * n_digits;
  endfunction

endpackage

// File: rtl/gs_digit_entry_if.sv
// Keypad-side control and edit-field/result bus for gs_digit_entry.
interface gs_digit_entry_if #(
    parameter int MAX_DIGITS = 2,
    parameter int VAL_W      = 6
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic                             start;
    logic                             digit_valid;
    logic [3:0]                       digit;
    logic                             backspace;
    logic                             commit;
    logic                             cancel;
    logic [MAX_DIGITS-1:0][3:0]       digits_buf;
    logic [CNT_W-1:0]                 digit_count;
    logic                             entry_active;
    logic                             busy;
    logic [VAL_W-1:0]                 value;
    logic                             value_valid;
    logic                             value_clamped;

    modport master (
        output start, digit_valid, digit, backspace, commit, cancel,
        input  digits_buf, digit_count, entry_active, busy,
               value, value_valid, value_clamped
    );

    modport slave (
        input  start, digit_valid, digit, backspace, commit, cancel,
        output digits_buf, digit_count, entry_active, busy,
               value, value_valid, value_clamped
    );
endinterface

// File: rtl/gs_digit_entry_bcd_mac.sv
// Combinational decimal multiply-add y = acc*10 + d, built from shifts so no
// multiplier is needed. Caller guarantees the result fits in W bits.
module gs_bcd_mac #(
    parameter int W = 8
) (
    input  logic [W-1:0] acc,
    input  logic [3:0]   d,
    output logic [W-1:0] y
);
    assign y = (acc << 3) + (acc << 1) + W'(d);
endmodule

// File: rtl/gs_digit_entry.sv
// Options-menu decimal entry: buffers typed BCD digits, converts them to binary
// one digit per cycle, clamps to [MIN_VAL, MAX_VAL] and strobes the result.
module gs_digit_entry
    import gs_digit_entry_pkg::*;
#(
    parameter int MAX_DIGITS = GS_DECIM_options_PIX_W_LEN,
    parameter int VAL_W      = 6,
    parameter int MIN_VAL    = GS_PIX_W_MIN,
    parameter int MAX_VAL    = GS_PIX_W_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    gs_digit_entry_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int ACC_W = gs_bcd_acc_width(MAX_DIGITS);
    localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    localparam logic [1:0] S_IDLE    = 2'(GSE_IDLE);
    localparam logic [1:0] S_ENTRY   = 2'(GSE_ENTRY);
    localparam logic [1:0] S_CONVERT = 2'(GSE_CONVERT);
    localparam logic [1:0] S_DONE    = 2'(GSE_DONE);

    logic [1:0]                 state;
    logic [MAX_DIGITS-1:0][3:0] buf_q;
    logic [CNT_W-1:0]           cnt;
    logic [ACC_W-1:0]           acc;
    logic [IDX_W-1:0]           idx;
    logic [VAL_W-1:0]           value_q;
    logic                       clamped_q;

    logic [MAX_DIGITS-1:0][3:0] push_buf;
    logic [MAX_DIGITS-1:0][3:0] pop_buf;
    logic [ACC_W-1:0]           mac_y;
    logic [VAL_W-1:0]           clamp_val;
    logic                       clamp_hit;

    gs_bcd_mac #(.W(ACC_W)) u_mac (
        .acc (acc),
        .d   (buf_q[idx]),
        .y   (mac_y)
    );

    // Index 0 is the most recently typed digit; pushes shift older digits up.
    always_comb begin
        push_buf    = '0;
        pop_buf     = '0;
        push_buf[0] = bus.digit;
        for (int i = 1; i < MAX_DIGITS; i++) push_buf[i] = buf_q[i-1];
        for (int i = 0; i < MAX_DIGITS - 1; i++) pop_buf[i] = buf_q[i+1];
    end

    always_comb begin
        clamp_val = mac_y[VAL_W-1:0];
        clamp_hit = 1'b0;
        if (mac_y < ACC_W'(MIN_VAL)) begin
            clamp_val = VAL_W'(MIN_VAL);
            clamp_hit = 1'b1;
        end else if (mac_y > ACC_W'(MAX_VAL)) begin
            clamp_val = VAL_W'(MAX_VAL);
            clamp_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            buf_q     <= '0;
            cnt       <= '0;
            acc       <= '0;
            idx       <= '0;
            value_q   <= VAL_W'(MIN_VAL);
            clamped_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        buf_q <= '0;
                        cnt   <= '0;
                        state <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else if (bus.start) begin
                        buf_q <= '0;
                        cnt   <= '0;
                    end else if (bus.commit) begin
                        if (cnt == '0) begin
                            state <= S_IDLE;
                        end else begin
                            acc   <= '0;
                            idx   <= IDX_W'(cnt - CNT_W'(1));
                            state <= S_CONVERT;
                        end
                    end else if (bus.backspace) begin
                        if (cnt != '0) begin
                            buf_q <= pop_buf;
                            cnt   <= cnt - CNT_W'(1);
                        end
                    end else if (bus.digit_valid && bus.digit <= 4'd9 &&
                                 cnt < CNT_W'(MAX_DIGITS)) begin
                        buf_q <= push_buf;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                S_CONVERT: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= mac_y;
                        // Result registers load on the last MAC step so they are
                        // already valid during the single DONE strobe cycle.
                        if (idx == '0) begin
                            value_q   <= clamp_val;
                            clamped_q <= clamp_hit;
                            state     <= S_DONE;
                        end else begin
                            idx <= idx - IDX_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.digits_buf    = buf_q;
    assign bus.digit_count   = cnt;
    assign bus.entry_active  = (state == S_ENTRY);
    assign bus.busy          = (state == S_CONVERT) || (state == S_DONE);
    assign bus.value         = value_q;
    assign bus.value_valid   = (state == S_DONE);
    assign bus.value_clamped = clamped_q;
endmodule

// File: tb/tb_gs_digit_entry.sv
// Directed bench for gs_digit_entry: a list-of-digits model checked every cycle
// plus literal expectations for each scenario.
module tb_gs_digit_entry;
    localparam int MAXD = 2;
    localparam int VW   = 6;
    localparam int MINV = 1;
    localparam int MAXV = 63;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    gs_digit_entry_if #(.MAX_DIGITS(MAXD), .VAL_W(VW)) bus ();

    gs_digit_entry #(.MAX_DIGITS(MAXD), .VAL_W(VW), .MIN_VAL(MINV), .MAX_VAL(MAXV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 typing, 2 converting, 3 result cycle.
    int m_mode, m_cnt, m_rem, m_target, m_val, m_clamp;
    int m_buf[MAXD];

    always @(posedge clk or negedge rst_n) begin : model
        int mode, cnt, rem, target, val, clamp;
        int b[MAXD];
        if (!rst_n) begin
            m_mode <= 0; m_cnt <= 0; m_rem <= 0; m_target <= 0;
            m_val <= MINV; m_clamp <= 0;
            for (int i = 0; i < MAXD; i++) m_buf[i] <= 0;
        end else begin
            mode = m_mode; cnt = m_cnt; rem = m_rem; target = m_target;
            val = m_val; clamp = m_clamp;
            for (int i = 0; i < MAXD; i++) b[i] = m_buf[i];
            case (mode)
                0: if (bus.start) begin
                    cnt = 0; for (int i = 0; i < MAXD; i++) b[i] = 0; mode = 1;
                end
                1: if (bus.cancel) mode = 0;
                   else if (bus.start) begin
                       cnt = 0; for (int i = 0; i < MAXD; i++) b[i] = 0;
                   end else if (bus.commit) begin
                       if (cnt == 0) mode = 0;
                       else begin
                           target = 0;
                           for (int k = 0; k < cnt; k++) target += b[k] * (10 ** k);
                           rem = cnt; mode = 2;
                       end
                   end else if (bus.backspace) begin
                       if (cnt > 0) begin
                           for (int i = 0; i < MAXD - 1; i++) b[i] = b[i+1];
                           b[MAXD-1] = 0; cnt--;
                       end
                   end else if (bus.digit_valid && bus.digit <= 9 && cnt < MAXD) begin
                       for (int i = MAXD - 1; i > 0; i--) b[i] = b[i-1];
                       b[0] = int'(bus.digit); cnt++;
                   end
                2: if (bus.cancel) mode = 0;
                   else begin
                       rem--;
                       if (rem == 0) begin
                           mode = 3;
                           if (target < MINV) begin val = MINV; clamp = 1; end
                           else if (target > MAXV) begin val = MAXV; clamp = 1; end
                           else begin val = target; clamp = 0; end
                       end
                   end
                default: mode = 0;
            endcase
            m_mode <= mode; m_cnt <= cnt; m_rem <= rem; m_target <= target;
            m_val <= val; m_clamp <= clamp;
            for (int i = 0; i < MAXD; i++) m_buf[i] <= b[i];
        end
    end

    always @(negedge clk) begin : compare
        logic [MAXD-1:0][3:0] exp_buf;
        if (chk_en) begin
            for (int i = 0; i < MAXD; i++) exp_buf[i] = 4'(m_buf[i]);
            check("cyc_digits_buf", 32'(bus.digits_buf), 32'(exp_buf));
            check("cyc_digit_count", 32'(bus.digit_count), m_cnt);
            check("cyc_entry_active", 32'(bus.entry_active), 32'(m_mode == 1));
            check("cyc_busy", 32'(bus.busy), 32'(m_mode == 2 || m_mode == 3));
            check("cyc_value_valid", 32'(bus.value_valid), 32'(m_mode == 3));
            check("cyc_value", 32'(bus.value), m_val);
            check("cyc_value_clamped", 32'(bus.value_clamped), m_clamp);
        end
    end

    task automatic drive(input logic s, input logic dv, input logic [3:0] d,
                         input logic bs, input logic cm, input logic cn);
        @(negedge clk);
        bus.start = s; bus.digit_valid = dv; bus.digit = d;
        bus.backspace = bs; bus.commit = cm; bus.cancel = cn;
    endtask

    task automatic idle();             drive(0, 0, 4'd0, 0, 0, 0); endtask
    task automatic start_entry();      drive(1, 0, 4'd0, 0, 0, 0); endtask
    task automatic key(input logic [3:0] d); drive(0, 1, d, 0, 0, 0); endtask
    task automatic do_commit();        drive(0, 0, 4'd0, 0, 1, 0); endtask

    // Counts cycles from the commit edge until the strobe, bounded.
    task automatic wait_strobe(input string name, input int lat, input int val, input int clamp);
        int n = 0;
        bit seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            idle();
            n = k;
            if (bus.value_valid) seen = 1'b1;
        end
        check({name, "_seen"}, 32'(seen), 1);
        check({name, "_latency"}, n, lat);
        check({name, "_value"}, 32'(bus.value), val);
        check({name, "_clamped"}, 32'(bus.value_clamped), clamp);
        idle();
        check({name, "_one_cycle"}, 32'(bus.value_valid), 0);
    endtask

    task automatic no_strobe(input string name, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            idle();
            check(name, 32'(bus.value_valid), 0);
        end
    endtask

    initial begin
        bus.start = 0; bus.digit_valid = 0; bus.digit = 0;
        bus.backspace = 0; bus.commit = 0; bus.cancel = 0;
        #12;
        check("rst_value", 32'(bus.value), 1);
        check("rst_count", 32'(bus.digit_count), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.value_valid), 0);
        check("rst_entry", 32'(bus.entry_active), 0);
        @(negedge clk); rst_n = 1'b1; chk_en = 1'b1;

        // 1,7 -> 17 after two conversion cycles
        start_entry(); key(4'd1); key(4'd7); do_commit();
        wait_strobe("v17", 3, 17, 0);
        check("v17_buf_kept", 32'(bus.digits_buf), 32'h17);

        start_entry(); key(4'd9); key(4'd9); do_commit();
        wait_strobe("v99", 3, 63, 1);

        start_entry(); key(4'd0); do_commit();
        wait_strobe("v0", 2, 1, 1);

        // invalid digit then empty commit: no result
        start_entry(); key(4'hA); do_commit();
        no_strobe("empty_no_strobe", 4);
        check("empty_count", 32'(bus.digit_count), 0);
        check("empty_idle", 32'(bus.entry_active), 0);
        check("empty_value", 32'(bus.value), 1);

        // third digit rejected, backspace, then 5
        start_entry(); key(4'd4); key(4'd2); key(4'd8); idle();
        check("full_count", 32'(bus.digit_count), 2);
        check("full_buf", 32'(bus.digits_buf), 32'h42);
        drive(0, 0, 4'd0, 1, 0, 0); idle();
        check("bs_count", 32'(bus.digit_count), 1);
        check("bs_buf0", 32'(bus.digits_buf[0]), 4);
        key(4'd5); do_commit();
        wait_strobe("v45", 3, 45, 0);

        // cancel during the first convert cycle
        start_entry(); key(4'd3); key(4'd3); do_commit();
        drive(0, 0, 4'd0, 0, 0, 1);
        no_strobe("cancel_no_strobe", 5);
        check("cancel_value", 32'(bus.value), 45);
        check("cancel_buf", 32'(bus.digits_buf), 32'h33);

        // commit beats backspace; 1 sits exactly on the lower bound
        start_entry(); key(4'd1); drive(0, 0, 4'd0, 1, 1, 0);
        wait_strobe("v1_commit_wins", 2, 1, 0);

        start_entry(); key(4'd6); key(4'd3); do_commit();
        wait_strobe("v63", 3, 63, 0);
        start_entry(); key(4'd6); key(4'd4); do_commit();
        wait_strobe("v64", 3, 63, 1);

        // async reset in the middle of a conversion
        start_entry(); key(4'd2); key(4'd5); do_commit(); idle();
        check("pre_rst_busy", 32'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_value", 32'(bus.value), 1);
        check("async_count", 32'(bus.digit_count), 0);
        check("async_busy", 32'(bus.busy), 0);
        idle(); idle();
        rst_n = 1'b1;
        no_strobe("post_rst_no_strobe", 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
